// File: rtl/memory_request_arbiter.sv
// memory_request_arbiter
// Serialises instruction fetches and data loads/stores from the datapath onto a
// single-port RAM. Data requests take priority over fetches. Each completion is
// reported with a one-cycle ihit/dhit pulse. A RAM that never answers is cut off
// after TIMEOUT cycles: the access completes, a read returns ERR_WORD, and err is set.
// Every output is a register.
module memory_request_arbiter #(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic        halt,
  output logic        ihit,
  output logic [31:0] iload,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_ready,
  output logic        err,
  output logic        halted,
  output logic [31:0] access_cnt
);

  localparam int            CW      = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DACC   = 2'd1,
    IACC   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] tcnt, tcnt_nx;
  logic          ren_nx, wen_nx, ihit_nx, dhit_nx, err_nx, halted_nx;
  logic [31:0]   addr_nx, store_nx, iload_nx, dload_nx, cnt_nx;
  logic [31:0]   rdata;

  // State and output registers; synchronous reset clears everything, aborting any access.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= IDLE;
      tcnt       <= '0;
      ramREN     <= 1'b0;
      ramWEN     <= 1'b0;
      ramaddr    <= 32'd0;
      ramstore   <= 32'd0;
      ihit       <= 1'b0;
      dhit       <= 1'b0;
      iload      <= 32'd0;
      dload      <= 32'd0;
      err        <= 1'b0;
      halted     <= 1'b0;
      access_cnt <= 32'd0;
    end else begin
      state      <= state_nx;
      tcnt       <= tcnt_nx;
      ramREN     <= ren_nx;
      ramWEN     <= wen_nx;
      ramaddr    <= addr_nx;
      ramstore   <= store_nx;
      ihit       <= ihit_nx;
      dhit       <= dhit_nx;
      iload      <= iload_nx;
      dload      <= dload_nx;
      err        <= err_nx;
      halted     <= halted_nx;
      access_cnt <= cnt_nx;
    end
  end

  // Next-state and next-output logic: request arbitration in IDLE, completion/timeout in an access.
  always_comb begin
    state_nx  = state;
    tcnt_nx   = tcnt;
    ren_nx    = ramREN;
    wen_nx    = ramWEN;
    addr_nx   = ramaddr;
    store_nx  = ramstore;
    ihit_nx   = 1'b0;
    dhit_nx   = 1'b0;
    iload_nx  = iload;
    dload_nx  = dload;
    err_nx    = err;
    cnt_nx    = access_cnt;
    // A timed-out read returns the error word instead of whatever is on the bus.
    rdata     = ram_ready ? ramload : ERR_WORD;

    case (state)
      IDLE: begin
        ren_nx = 1'b0;
        wen_nx = 1'b0;
        if (halt) begin
          state_nx = HALTED;
        end else if (dWEN) begin
          state_nx = DACC;
          wen_nx   = 1'b1;
          addr_nx  = daddr;
          store_nx = dstore;
          tcnt_nx  = '0;
        end else if (dREN) begin
          state_nx = DACC;
          ren_nx   = 1'b1;
          addr_nx  = daddr;
          tcnt_nx  = '0;
        end else if (iREN) begin
          state_nx = IACC;
          ren_nx   = 1'b1;
          addr_nx  = iaddr;
          tcnt_nx  = '0;
        end else begin
          state_nx = IDLE;
        end
      end

      DACC, IACC: begin
        if (ram_ready || (tcnt == TO_LAST)) begin
          state_nx = IDLE;
          ren_nx   = 1'b0;
          wen_nx   = 1'b0;
          cnt_nx   = access_cnt + 32'd1;
          if (!ram_ready) begin
            err_nx = 1'b1;
          end else begin
            err_nx = err;
          end
          if (state == DACC) begin
            dhit_nx = 1'b1;
            if (ramREN) begin
              dload_nx = rdata;
            end else begin
              dload_nx = dload;
            end
          end else begin
            ihit_nx  = 1'b1;
            iload_nx = rdata;
          end
        end else begin
          tcnt_nx = tcnt + {{(CW-1){1'b0}}, 1'b1};
        end
      end

      HALTED: begin
        state_nx = HALTED;
        ren_nx   = 1'b0;
        wen_nx   = 1'b0;
      end

      default: begin
        state_nx = IDLE;
        ren_nx   = 1'b0;
        wen_nx   = 1'b0;
      end
    endcase

    halted_nx = (state_nx == HALTED);
  end

endmodule

// File: tb/tb_memory_request_arbiter.sv
// Directed bench for memory_request_arbiter: fetch latency, data priority,
// write precedence, timeout error path, halt behaviour and mid-access reset.
module tb_memory_request_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN, halt, ram_ready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        ihit, dhit, ramREN, ramWEN, err, halted;
  logic [31:0] iload, dload, ramaddr, ramstore, access_cnt;

  int checks   = 0;
  int failures = 0;
  int n;

  memory_request_arbiter #(.TIMEOUT(16), .ERR_WORD(32'hBAD1BAD1)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .halt(halt),
    .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready),
    .err(err), .halted(halted), .access_cnt(access_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; halt = 1'b0; ram_ready = 1'b0;
    iaddr = 32'd0; daddr = 32'd0; dstore = 32'd0; ramload = 32'd0;

    // Reset state
    @(negedge CLK); @(negedge CLK);
    check("rst_ramREN", {31'd0, ramREN}, 32'd0);
    check("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
    check("rst_hits", {30'd0, ihit, dhit}, 32'd0);
    check("rst_iload", iload, 32'd0);
    check("rst_dload", dload, 32'd0);
    check("rst_ramaddr", ramaddr, 32'd0);
    check("rst_err_halted", {30'd0, err, halted}, 32'd0);
    check("rst_cnt", access_cnt, 32'd0);
    nRST = 1'b1;

    // T1: fetch, ready in the 4th strobe cycle
    @(negedge CLK);
    iREN = 1'b1; iaddr = 32'h40; ramload = 32'h2001000A;
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      check("t1_ramREN", {31'd0, ramREN}, 32'd1);
      check("t1_no_ihit", {31'd0, ihit}, 32'd0);
      if (k == 1) check("t1_ramaddr", ramaddr, 32'h40);
      if (k == 4) ram_ready = 1'b1;
    end
    @(negedge CLK);
    check("t1_ihit", {31'd0, ihit}, 32'd1);
    check("t1_strobe_drop", {31'd0, ramREN}, 32'd0);
    check("t1_iload", iload, 32'h2001000A);
    check("t1_cnt", access_cnt, 32'd1);
    iREN = 1'b0; ram_ready = 1'b0;
    @(negedge CLK);
    check("t1_ihit_pulse", {31'd0, ihit}, 32'd0);
    check("t1_no_new_acc", {31'd0, ramREN}, 32'd0);

    // T2: data read and fetch together, data first
    dREN = 1'b1; daddr = 32'h100; iREN = 1'b1; iaddr = 32'h44;
    ram_ready = 1'b1; ramload = 32'h11112222;
    @(negedge CLK); // cycle 1
    check("t2_d_ramaddr", ramaddr, 32'h100);
    check("t2_d_ramREN", {31'd0, ramREN}, 32'd1);
    @(negedge CLK); // cycle 2
    check("t2_dhit", {31'd0, dhit}, 32'd1);
    check("t2_no_ihit_c2", {31'd0, ihit}, 32'd0);
    check("t2_dload", dload, 32'h11112222);
    dREN = 1'b0;
    @(negedge CLK); // cycle 3
    check("t2_i_ramaddr", ramaddr, 32'h44);
    check("t2_i_ramREN", {31'd0, ramREN}, 32'd1);
    ramload = 32'h33334444;
    @(negedge CLK); // cycle 4
    check("t2_ihit", {31'd0, ihit}, 32'd1);
    check("t2_no_dhit_c4", {31'd0, dhit}, 32'd0);
    check("t2_iload", iload, 32'h33334444);
    check("t2_cnt", access_cnt, 32'd3);
    iREN = 1'b0; ram_ready = 1'b0;
    @(negedge CLK);

    // T3: write wins over read
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; dstore = 32'hCAFEF00D;
    @(negedge CLK);
    check("t3_ramWEN", {31'd0, ramWEN}, 32'd1);
    check("t3_ramREN", {31'd0, ramREN}, 32'd0);
    check("t3_ramstore", ramstore, 32'hCAFEF00D);
    check("t3_ramaddr", ramaddr, 32'h200);
    dstore = 32'h0; daddr = 32'h0; // mid-access changes must be ignored
    @(negedge CLK);
    check("t3_latched_store", ramstore, 32'hCAFEF00D);
    ram_ready = 1'b1; ramload = 32'hDEADBEEF;
    @(negedge CLK);
    check("t3_dhit", {31'd0, dhit}, 32'd1);
    check("t3_dload_kept", dload, 32'h11112222);
    check("t3_wen_drop", {31'd0, ramWEN}, 32'd0);
    dREN = 1'b0; dWEN = 1'b0; ram_ready = 1'b0;
    @(negedge CLK);

    // T4: read timeout
    dREN = 1'b1; daddr = 32'h300;
    n = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLK);
      if (ramREN) n++;
      if (k == 16) check("t4_err_before", {31'd0, err}, 32'd0);
    end
    check("t4_strobe_cycles", n, 32'd16);
    @(negedge CLK);
    check("t4_strobe_drop", {31'd0, ramREN}, 32'd0);
    check("t4_dhit", {31'd0, dhit}, 32'd1);
    check("t4_dload", dload, 32'hBAD1BAD1);
    check("t4_err", {31'd0, err}, 32'd1);
    check("t4_cnt", access_cnt, 32'd5);
    dREN = 1'b0;
    @(negedge CLK); @(negedge CLK);
    check("t4_err_sticky", {31'd0, err}, 32'd1);

    // T5: halt mid-fetch
    iREN = 1'b1; iaddr = 32'h50; ramload = 32'h0BADF00D;
    @(negedge CLK); // cycle 1
    check("t5_ramREN", {31'd0, ramREN}, 32'd1);
    halt = 1'b1;
    @(negedge CLK); // cycle 2
    check("t5_still_acc", {31'd0, ramREN}, 32'd1);
    ram_ready = 1'b1;
    @(negedge CLK); // cycle 3
    check("t5_ihit", {31'd0, ihit}, 32'd1);
    check("t5_iload", iload, 32'h0BADF00D);
    check("t5_not_halted_yet", {31'd0, halted}, 32'd0);
    @(negedge CLK); // cycle 4
    check("t5_halted", {31'd0, halted}, 32'd1);
    n = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      if (ramREN || ramWEN || ihit || dhit || !halted) n++;
    end
    check("t5_absorbing", n, 32'd0);
    check("t5_cnt", access_cnt, 32'd6);

    // T6: reset while ramWEN high
    nRST = 1'b0; iREN = 1'b0; halt = 1'b0; ram_ready = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    check("t6_unhalted", {31'd0, halted}, 32'd0);
    dWEN = 1'b1; daddr = 32'h400; dstore = 32'h1;
    @(negedge CLK);
    check("t6_ramWEN", {31'd0, ramWEN}, 32'd1);
    nRST = 1'b0;
    @(negedge CLK);
    check("t6_strobe_drop", {30'd0, ramWEN, ramREN}, 32'd0);
    check("t6_no_dhit", {31'd0, dhit}, 32'd0);
    check("t6_cnt", access_cnt, 32'd0);
    check("t6_err", {31'd0, err}, 32'd0);
    nRST = 1'b1; dWEN = 1'b0; ram_ready = 1'b1;
    @(negedge CLK);
    check("t6_no_late_dhit", {31'd0, dhit}, 32'd0);
    check("t6_idle", {30'd0, ramWEN, ramREN}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
